code_mon_mc: RTL

Parametrised multi-channel line-code monitor. Each of NCH receive channels has its own lock/idle state machine, saturating error counter and data capture. All channels share one CPU register interface with clear-on-read counters, write-1-to-clear sticky errors and an interrupt. The block sits between the per-lane symbol decoders and the core fabric, and extends the single-channel decoder core with channel count, width generics, error-threshold relock, a test-injection mode and an interrupt.

---
 rtl/code_mon_pkg.sv | 27 ++
 rtl/code_mon_chan.sv | 142 ++++++++++++++
 rtl/code_mon_mc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/code_mon_pkg.sv
// ---------------------------------------------------------------------------
// code_mon_pkg
// Shared definitions for the multi-channel line-code monitor: the per-channel
// lock state encoding and the CPU register address map.
// ---------------------------------------------------------------------------
package code_mon_pkg;

  // Encoding is visible to software through the STATE[c] registers.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } chan_state_e;

  // Register map (word addresses).
  localparam int ADDR_CTRL       = 'h00;
  localparam int ADDR_STATUS     = 'h01;
  localparam int ADDR_ERR_STICKY = 'h02;
  localparam int ADDR_TEST       = 'h03;
  localparam int ADDR_ERR_THRESH = 'h04;
  localparam int ADDR_ERR_CNT    = 'h08;  // + channel index
  localparam int ADDR_STATE      = 'h10;  // + channel index

  // Bit position of irq_en inside CTRL.
  localparam int CTRL_IRQ_EN_BIT = 1;

endpackage : code_mon_pkg

// File: rtl/code_mon_chan.sv
// ---------------------------------------------------------------------------
// code_mon_chan
// One receive channel: idle-run lock detector, SEARCH/IDLE/ACTIVE state
// machine, saturating error counter with threshold relock, and data capture.
//
// Ports
//   clock, reset    rising-edge clock, asynchronous active-low reset
//   afe_ctrl        0 forces SEARCH and ignores the symbol inputs
//   sym_valid       symbol strobe (already muxed for test mode)
//   sym_data        symbol value
//   sym_err         decoder error flag, qualified by sym_valid
//   err_thresh      relock threshold; 0 disables relock
//   cnt_clr         clear-on-read strobe for the error counter
//   state           current lock state
//   err_cnt         saturating error count
//   data            last emitted data symbol
//   data_valid      one-cycle pulse per emitted symbol
//   err_hit         combinational: an error is being counted this cycle
// ---------------------------------------------------------------------------
module code_mon_chan
  import code_mon_pkg::*;
#(
  parameter int              DW       = 8,
  parameter logic [DW-1:0]   IDLE_SYM = DW'(8'hBC),
  parameter int              IDLE_RUN = 4,
  parameter int              ERR_CW   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              afe_ctrl,
  input  logic              sym_valid,
  input  logic [DW-1:0]     sym_data,
  input  logic              sym_err,
  input  logic [DW-1:0]     err_thresh,
  input  logic              cnt_clr,
  output chan_state_e       state,
  output logic [ERR_CW-1:0] err_cnt,
  output logic [DW-1:0]     data,
  output logic              data_valid,
  output logic              err_hit
);

  localparam int RW = $clog2(IDLE_RUN + 1);

  chan_state_e       state_q, state_d;
  logic [RW-1:0]     run_q, run_d;
  logic [ERR_CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;

  logic              is_err, is_idle, is_data;
  logic [ERR_CW-1:0] cnt_base, cnt_inc;

  assign is_err  = sym_valid & sym_err;
  assign is_idle = sym_valid & ~sym_err & (sym_data == IDLE_SYM);
  assign is_data = sym_valid & ~sym_err & (sym_data != IDLE_SYM);

  // A clear-on-read in the same cycle as an increment must load 1, so the
  // increment is applied on top of the already-cleared value.
  assign cnt_base = cnt_clr ? '0 : cnt_q;
  assign cnt_inc  = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_base;
    data_d  = data_q;
    valid_d = 1'b0;
    err_hit = 1'b0;

    if (!afe_ctrl) begin
      state_d = ST_SEARCH;
      run_d   = '0;
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          if (is_idle) begin
            if (run_q == RW'(IDLE_RUN - 1)) begin
              state_d = ST_IDLE;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else if (is_data || is_err) begin
            run_d = '0;
          end
        end
        ST_IDLE: begin
          if (is_data) begin
            state_d = ST_ACTIVE;
            data_d  = sym_data;
            valid_d = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (is_data) begin
            data_d  = sym_data;
            valid_d = 1'b1;
          end else if (is_idle) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_SEARCH;
      endcase

      // Errors only count once locked; the counter survives the relock.
      if (is_err && (state_q == ST_IDLE || state_q == ST_ACTIVE)) begin
        err_hit = 1'b1;
        cnt_d   = cnt_inc;
        if (err_thresh != '0 && DW'(cnt_inc) >= err_thresh) begin
          state_d = ST_SEARCH;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SEARCH;
      run_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign state      = state_q;
  assign err_cnt    = cnt_q;
  assign data       = data_q;
  assign data_valid = valid_q;

endmodule : code_mon_chan

// File: rtl/code_mon_mc.sv
// ---------------------------------------------------------------------------
// code_mon_mc
// Multi-channel line-code monitor. NCH independent channel monitors share one
// CPU register interface (clear-on-read counters, W1C sticky errors) and a
// registered interrupt. A test mode feeds the TEST register to every channel.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   afe_ctrl          front-end ready; 0 holds every channel in SEARCH
//   test_enable       1 = all channels see TEST as a valid error-free symbol
//   ch_valid/ch_data/ch_code_err   per-channel symbol inputs
//   cpu_wr/cpu_rd/cpu_addr/cpu_wdata   register access
//   core_data/core_data_valid      per-channel emitted data
//   core_code_error   ERR_STICKY bits
//   core_code_idle    1 while a channel is in IDLE
//   cpu_rdata         registered read data, held until the next read
//   irq               registered irq_en & |ERR_STICKY
// ---------------------------------------------------------------------------
module code_mon_mc
  import code_mon_pkg::*;
#(
  parameter int            NCH        = 4,
  parameter int            DW         = 8,
  parameter int            AW         = 5,
  parameter logic [DW-1:0] IDLE_SYM   = DW'(8'hBC),
  parameter int            IDLE_RUN   = 4,
  parameter int            ERR_CW     = 8,
  parameter int            THRESH_RST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              afe_ctrl,
  input  logic              test_enable,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_code_err,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [NCH*DW-1:0] core_data,
  output logic [NCH-1:0]    core_data_valid,
  output logic [NCH-1:0]    core_code_error,
  output logic [NCH-1:0]    core_code_idle,
  output logic [DW-1:0]     cpu_rdata,
  output logic              irq
);

  // Register file.
  logic            irq_en_q, irq_en_d;
  logic [NCH-1:0]  sticky_q, sticky_d;
  logic [DW-1:0]   test_q, test_d;
  logic [DW-1:0]   thresh_q, thresh_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            irq_q, irq_d;

  // Per-channel views.
  chan_state_e       ch_state [NCH];
  logic [ERR_CW-1:0] ch_cnt   [NCH];
  logic [NCH-1:0]    ch_err_hit;
  logic [NCH-1:0]    ch_cnt_clr;

  logic wr_ctrl, wr_sticky, wr_test, wr_thresh;

  assign wr_ctrl   = cpu_wr && (cpu_addr == AW'(ADDR_CTRL));
  assign wr_sticky = cpu_wr && (cpu_addr == AW'(ADDR_ERR_STICKY));
  assign wr_test   = cpu_wr && (cpu_addr == AW'(ADDR_TEST));
  assign wr_thresh = cpu_wr && (cpu_addr == AW'(ADDR_ERR_THRESH));

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic          sym_valid, sym_err;
    logic [DW-1:0] sym_data;

    // Test mode substitutes the TEST register as a clean symbol on every lane.
    assign sym_valid = test_enable | ch_valid[c];
    assign sym_data  = test_enable ? test_q : ch_data[c*DW +: DW];
    assign sym_err   = test_enable ? 1'b0   : ch_code_err[c];

    assign ch_cnt_clr[c] = cpu_rd && (cpu_addr == AW'(ADDR_ERR_CNT + c));

    code_mon_chan #(
      .DW       (DW),
      .IDLE_SYM (IDLE_SYM),
      .IDLE_RUN (IDLE_RUN),
      .ERR_CW   (ERR_CW)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .afe_ctrl   (afe_ctrl),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .sym_err    (sym_err),
      .err_thresh (thresh_q),
      .cnt_clr    (ch_cnt_clr[c]),
      .state      (ch_state[c]),
      .err_cnt    (ch_cnt[c]),
      .data       (core_data[c*DW +: DW]),
      .data_valid (core_data_valid[c]),
      .err_hit    (ch_err_hit[c])
    );

    assign core_code_idle[c] = (ch_state[c] == ST_IDLE);
  end

  // Register updates and read mux. Reads sample the current (pre-edge)
  // register values, so a same-cycle write or clear is not visible.
  always_comb begin
    logic [DW-1:0] rd_mux;

    irq_en_d = irq_en_q;
    test_d   = test_q;
    thresh_d = thresh_q;
    rdata_d  = rdata_q;
    rd_mux   = '0;

    if (wr_ctrl)   irq_en_d = cpu_wdata[CTRL_IRQ_EN_BIT];
    if (wr_test)   test_d   = cpu_wdata;
    if (wr_thresh) thresh_d = cpu_wdata;

    // A new error in the same cycle as its W1C keeps the bit set.
    sticky_d = (sticky_q & ~(wr_sticky ? cpu_wdata[NCH-1:0] : '0)) | ch_err_hit;

    if (cpu_addr == AW'(ADDR_CTRL)) begin
      rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (cpu_addr == AW'(ADDR_STATUS)) begin
      rd_mux[NCH-1:0] = core_code_idle;
    end else if (cpu_addr == AW'(ADDR_ERR_STICKY)) begin
      rd_mux[NCH-1:0] = sticky_q;
    end else if (cpu_addr == AW'(ADDR_TEST)) begin
      rd_mux = test_q;
    end else if (cpu_addr == AW'(ADDR_ERR_THRESH)) begin
      rd_mux = thresh_q;
    end
    for (int c = 0; c < NCH; c++) begin
      if (cpu_addr == AW'(ADDR_ERR_CNT + c)) rd_mux[ERR_CW-1:0] = ch_cnt[c];
      if (cpu_addr == AW'(ADDR_STATE + c))   rd_mux[1:0]        = ch_state[c];
    end

    if (cpu_rd) rdata_d = rd_mux;

    irq_d = irq_en_q & (|sticky_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      sticky_q <= '0;
      test_q   <= '0;
      thresh_q <= DW'(THRESH_RST);
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      sticky_q <= sticky_d;
      test_q   <= test_d;
      thresh_q <= thresh_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign core_code_error = sticky_q;
  assign cpu_rdata       = rdata_q;
  assign irq             = irq_q;

endmodule : code_mon_mc
